// File: rtl/uparc_except_unit_pkg.sv
// Shared constants for the exception unit: cause codes, stage-kill masks and FSM encoding.
package uparc_except_unit_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] CAUSE_INTR    = 4'd0;
    localparam logic [3:0] CAUSE_SYSCALL = 4'd1;
    localparam logic [3:0] CAUSE_BREAK   = 4'd2;
    localparam logic [3:0] CAUSE_DECODE  = 4'd3;
    localparam logic [3:0] CAUSE_BUS     = 4'd4;

    // Bit positions inside the writeback exception vector
    localparam int EXC_SYSCALL = 0;
    localparam int EXC_BREAK   = 1;
    localparam int EXC_DECODE  = 2;
    localparam int EXC_BUS     = 3;

    // Stage kill masks, bit order {wb, mem, execute, decode}
    localparam logic [3:0] KILL_NONE   = 4'b0000;
    localparam logic [3:0] KILL_DECODE = 4'b0001;
    localparam logic [3:0] KILL_ALL    = 4'b1111;

    localparam int CNT_W = 3;

    // Highest-severity synchronous exception wins; zero vector means interrupt
    function automatic logic [3:0] exc_cause(input logic [3:0] exc);
        if (exc[EXC_BUS])     return CAUSE_BUS;
        if (exc[EXC_DECODE])  return CAUSE_DECODE;
        if (exc[EXC_BREAK])   return CAUSE_BREAK;
        if (exc[EXC_SYSCALL]) return CAUSE_SYSCALL;
        return CAUSE_INTR;
    endfunction

endpackage

// File: rtl/uparc_sync2.sv
// Two-flop level synchronizer for an asynchronous input into the clk domain.
module uparc_sync2 (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], d};
        end
    end

    assign q = sync_reg[1];

endmodule

// File: rtl/uparc_except_unit.sv
// Exception/interrupt entry controller: detects writeback events, redirects fetch
// to the vector table and nullifies the pipeline while the redirect settles.
module uparc_except_unit
    import uparc_except_unit_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_exec_stall,
    input  logic        i_mem_stall,
    input  logic        i_fetch_stall,
    input  logic        i_cop0_ie,
    input  logic [21:0] i_cop0_ivtbase,
    input  logic        i_intr,
    input  logic        i_wb_valid,
    input  logic [31:0] i_wb_pc,
    input  logic        i_wb_bd,
    input  logic [3:0]  i_wb_exc,
    output logic        o_except_start,
    output logic        o_except_dly_slt,
    output logic [31:0] o_except_raddr,
    output logic [31:0] o_except_raddr_dly,
    output logic [3:0]  o_except_cause,
    output logic        o_nullify_decode,
    output logic        o_nullify_execute,
    output logic        o_nullify_mem,
    output logic        o_nullify_wb,
    output logic        o_jump_valid,
    output logic [31:0] o_jump_addr
);

    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             intr_sync;
    logic             intr_req;
    logic             core_stall;
    logic             exc_event;
    logic [3:0]       event_cause;
    logic [3:0]       kill;

    uparc_sync2 u_intr_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (i_intr),
        .q    (intr_sync)
    );

    assign core_stall  = i_exec_stall | i_mem_stall | i_fetch_stall;
    assign intr_req    = intr_sync & i_cop0_ie;
    assign event_cause = exc_cause(i_wb_exc);

    // Gated by nrst so that outputs stay quiet for the whole reset assertion
    assign exc_event = nrst && (state_reg == ST_IDLE) && i_wb_valid &&
                       ((i_wb_exc != 4'b0000) || intr_req);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        cnt_next           = cnt_reg;
        kill               = KILL_NONE;
        o_except_start     = 1'b0;
        o_except_dly_slt   = 1'b0;
        o_except_raddr     = '0;
        o_except_raddr_dly = '0;
        o_except_cause     = '0;
        o_jump_valid       = 1'b0;
        o_jump_addr        = '0;

        case (state_reg)
            ST_IDLE: begin
                if (exc_event) begin
                    kill               = KILL_ALL;
                    o_except_start     = 1'b1;
                    o_except_dly_slt   = i_wb_bd;
                    o_except_raddr     = i_wb_pc;
                    o_except_raddr_dly = i_wb_pc - 32'd4;
                    o_except_cause     = event_cause;
                    o_jump_valid       = 1'b1;
                    o_jump_addr        = {i_cop0_ivtbase, 4'b0000, event_cause, 2'b00};
                    // A stalled entry is re-presented until the pipeline moves
                    if (!core_stall) begin
                        state_next = ST_FLUSH;
                        cnt_next   = FLUSH_LOAD;
                    end
                end
            end
            ST_FLUSH: begin
                kill = KILL_DECODE;
                if (!core_stall) begin
                    cnt_next = cnt_reg - 3'd1;
                    if (cnt_reg <= 3'd1) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign {o_nullify_wb, o_nullify_mem, o_nullify_execute, o_nullify_decode} = kill;

endmodule

// File: tb/tb_uparc_except_unit.sv
// Self-checking bench for uparc_except_unit: directed scenarios plus a random stream
// compared each cycle against a behavioural model of entry, flush and interrupt sync.
module tb_uparc_except_unit;

    localparam int FC = 3;
    localparam logic [106:0] FLUSH_PAT = 107'(1) << 33;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        i_exec_stall = 1'b0, i_mem_stall = 1'b0, i_fetch_stall = 1'b0;
    logic        i_cop0_ie = 1'b0;
    logic [21:0] i_cop0_ivtbase = '0;
    logic        i_intr = 1'b0;
    logic        i_wb_valid = 1'b0;
    logic [31:0] i_wb_pc = '0;
    logic        i_wb_bd = 1'b0;
    logic [3:0]  i_wb_exc = '0;
    logic        o_except_start, o_except_dly_slt;
    logic [31:0] o_except_raddr, o_except_raddr_dly;
    logic [3:0]  o_except_cause;
    logic        o_nullify_decode, o_nullify_execute, o_nullify_mem, o_nullify_wb;
    logic        o_jump_valid;
    logic [31:0] o_jump_addr;

    uparc_except_unit #(.FLUSH_CYCLES(FC)) dut (
        .clk                (clk),
        .nrst               (nrst),
        .i_exec_stall       (i_exec_stall),
        .i_mem_stall        (i_mem_stall),
        .i_fetch_stall      (i_fetch_stall),
        .i_cop0_ie          (i_cop0_ie),
        .i_cop0_ivtbase     (i_cop0_ivtbase),
        .i_intr             (i_intr),
        .i_wb_valid         (i_wb_valid),
        .i_wb_pc            (i_wb_pc),
        .i_wb_bd            (i_wb_bd),
        .i_wb_exc           (i_wb_exc),
        .o_except_start     (o_except_start),
        .o_except_dly_slt   (o_except_dly_slt),
        .o_except_raddr     (o_except_raddr),
        .o_except_raddr_dly (o_except_raddr_dly),
        .o_except_cause     (o_except_cause),
        .o_nullify_decode   (o_nullify_decode),
        .o_nullify_execute  (o_nullify_execute),
        .o_nullify_mem      (o_nullify_mem),
        .o_nullify_wb       (o_nullify_wb),
        .o_jump_valid       (o_jump_valid),
        .o_jump_addr        (o_jump_addr)
    );

    always #5 clk = ~clk;

    logic [106:0] obs, want;
    assign obs = {o_except_start, o_except_dly_slt, o_except_raddr, o_except_raddr_dly,
                  o_except_cause, o_nullify_wb, o_nullify_mem, o_nullify_execute,
                  o_nullify_decode, o_jump_valid, o_jump_addr};

    int errors = 0;
    int checks = 0;

    // Model state: unstalled flush cycles still owed, and the two-edge interrupt history
    int m_left = 0;
    bit m_s1 = 1'b0;
    bit m_s2 = 1'b0;

    function automatic logic [3:0] ref_cause(input logic [3:0] exc);
        for (int b = 3; b >= 0; b--) begin
            if (exc[b]) return 4'(b + 1);
        end
        return 4'd0;
    endfunction

    function automatic bit ref_event();
        return i_wb_valid && ((i_wb_exc != 4'd0) || (m_s2 && i_cop0_ie));
    endfunction

    function automatic logic [106:0] ref_out();
        logic [3:0] c;
        if (!nrst) return '0;
        if (m_left > 0) return FLUSH_PAT;
        if (!ref_event()) return '0;
        c = ref_cause(i_wb_exc);
        return {1'b1, i_wb_bd, i_wb_pc, i_wb_pc - 32'd4, c, 4'b1111, 1'b1,
                i_cop0_ivtbase, 4'b0000, c, 2'b00};
    endfunction

    task automatic model_reset();
        m_left = 0;
        m_s1   = 1'b0;
        m_s2   = 1'b0;
    endtask

    // Advance one clock edge; the model consumes the inputs present at that edge
    task automatic tick();
        bit ev;
        bit stall;
        @(posedge clk);
        ev    = ref_event();
        stall = i_exec_stall || i_mem_stall || i_fetch_stall;
        if (nrst) begin
            if (m_left > 0) begin
                if (!stall) m_left--;
            end else if (ev && !stall) begin
                m_left = FC;
            end
            m_s2 = m_s1;
            m_s1 = i_intr;
        end
        #1;
    endtask

    task automatic idle_inputs();
        i_exec_stall = 1'b0; i_mem_stall = 1'b0; i_fetch_stall = 1'b0;
        i_wb_valid = 1'b0; i_wb_exc = '0; i_wb_bd = 1'b0; i_wb_pc = '0;
        i_intr = 1'b0; i_cop0_ie = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        for (int i = 0; i < 20 && (m_left > 0 || m_s1 || m_s2); i++) tick();
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        model_reset();
        i_wb_valid = 1'b1; i_wb_exc = 4'b0001; i_intr = 1'b1; i_cop0_ie = 1'b1;
        i_wb_pc = 32'h0000_1234; i_cop0_ivtbase = 22'h3;
        for (int i = 0; i < 3; i++) begin
            tick();
            #4;
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL reset_quiet cyc=%0d got=%h want=0", i, obs);
            end
        end
        tick();
        idle_inputs();
        nrst = 1'b1;
        #4;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_release got=%h want=0", obs);
        end
    endtask

    task automatic test_syscall();
        tick();
        i_wb_valid = 1'b1; i_wb_exc = 4'b0001; i_wb_pc = 32'h0000_1000;
        i_cop0_ivtbase = 22'h000001; i_wb_bd = 1'b0;
        #4;
        checks++;
        if ({o_except_start, o_except_cause, o_jump_addr, o_except_raddr, o_nullify_wb,
             o_nullify_mem, o_nullify_execute, o_nullify_decode, o_jump_valid} !==
            {1'b1, 4'd1, 32'h0000_0404, 32'h0000_1000, 4'hF, 1'b1}) begin
            errors++;
            $display("FAIL syscall_entry got=%h want start/cause1/jump404/raddr1000/kill_all", obs);
        end
        for (int i = 0; i <= FC; i++) begin
            tick();
            i_wb_valid = 1'b0; i_wb_exc = '0;
            #4;
            want = (i < FC) ? FLUSH_PAT : '0;
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL syscall_flush cyc=%0d got=%h want=%h", i, obs, want);
            end
        end
    endtask

    task automatic test_priority_bd();
        tick();
        i_wb_valid = 1'b1; i_wb_exc = 4'b1010; i_wb_bd = 1'b1; i_wb_pc = 32'h0000_2004;
        #4;
        checks++;
        if ({o_except_start, o_except_cause, o_except_dly_slt, o_except_raddr_dly} !==
            {1'b1, 4'd4, 1'b1, 32'h0000_2000}) begin
            errors++;
            $display("FAIL bus_bd_entry got=%h want start cause4 dly1 raddr_dly=00002000", obs);
        end
        // New exceptions arriving during the flush must be ignored
        for (int i = 0; i < FC; i++) begin
            tick();
            i_wb_exc = 4'b0100; i_wb_bd = 1'b0; i_wb_pc = $urandom;
            #4;
            checks++;
            if (obs !== FLUSH_PAT) begin
                errors++;
                $display("FAIL flush_ignores cyc=%0d got=%h want=%h", i, obs, FLUSH_PAT);
            end
        end
        tick();
        i_wb_pc = 32'h0000_0000;
        #4;
        checks++;
        if ({o_except_start, o_except_cause, o_except_raddr_dly} !== {1'b1, 4'd3, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL pc0_wrap got=%h want start cause3 raddr_dly=fffffffc", obs);
        end
        want = ref_out();
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL pc0_model got=%h want=%h", obs, want);
        end
        tick();
        drain();
    endtask

    task automatic test_interrupt();
        i_cop0_ie = 1'b1; i_wb_valid = 1'b1; i_wb_exc = '0; i_wb_pc = 32'h0000_3000;
        i_cop0_ivtbase = 22'h2A5A5;
        i_intr = 1'b1;
        #4;
        for (int e = 0; e < 3; e++) begin
            checks++;
            if (e < 2 && o_except_start !== 1'b0) begin
                errors++;
                $display("FAIL intr_early edges=%0d start=%b want=0", e, o_except_start);
            end else if (e == 2 && {o_except_start, o_except_cause, o_jump_addr} !==
                     {1'b1, 4'd0, i_cop0_ivtbase, 10'd0}) begin
                errors++;
                $display("FAIL intr_entry got=%h want start cause0 jump=%h", obs, {i_cop0_ivtbase, 10'd0});
            end
            if (e < 2) begin
                tick();
                #4;
            end
        end
        tick();
        drain();
        i_cop0_ie = 1'b0; i_wb_valid = 1'b1; i_intr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            #4;
            checks++;
            if (o_except_start !== 1'b0 || obs !== ref_out()) begin
                errors++;
                $display("FAIL intr_masked cyc=%0d got=%h want=%h", i, obs, ref_out());
            end
        end
        tick();
        drain();
    endtask

    task automatic test_stall();
        i_mem_stall = 1'b1; i_wb_valid = 1'b1; i_wb_exc = 4'b0100; i_wb_pc = 32'h0000_5008;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) i_mem_stall = 1'b0;
            #4;
            checks++;
            if (o_except_start !== 1'b1 || o_except_cause !== 4'd3 || obs !== ref_out()) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got=%h want=%h", i, obs, ref_out());
            end
            tick();
        end
        i_wb_valid = 1'b0; i_wb_exc = '0;
        #4;
        checks++;
        if (obs !== FLUSH_PAT) begin
            errors++;
            $display("FAIL stall_then_flush got=%h want=%h", obs, FLUSH_PAT);
        end
        drain();
    endtask

    task automatic test_reset_mid_flush();
        i_wb_valid = 1'b1; i_wb_exc = 4'b0010; i_wb_pc = 32'h0000_6000;
        tick();
        i_wb_valid = 1'b0; i_wb_exc = '0;
        #2;
        checks++;
        if (obs !== FLUSH_PAT) begin
            errors++;
            $display("FAIL pre_reset_flush got=%h want=%h", obs, FLUSH_PAT);
        end
        nrst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_abort got=%h want=0", obs);
        end
        tick();
        nrst = 1'b1;
        i_wb_valid = 1'b1; i_wb_exc = 4'b0001; i_wb_pc = 32'h0000_7000;
        #4;
        checks++;
        if (o_except_start !== 1'b1 || obs !== ref_out()) begin
            errors++;
            $display("FAIL idle_after_reset got=%h want=%h", obs, ref_out());
        end
        tick();
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            int r;
            tick();
            r = int'($urandom_range(0, 7));
            i_wb_valid     = ($urandom_range(0, 3) != 0);
            i_wb_exc       = (r == 4) ? 4'(1 << $urandom_range(0, 3)) :
                             (r == 5) ? 4'($urandom) : 4'd0;
            i_exec_stall   = ($urandom_range(0, 9) == 0);
            i_mem_stall    = ($urandom_range(0, 9) == 0);
            i_fetch_stall  = ($urandom_range(0, 9) == 0);
            i_cop0_ie      = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) i_intr = ~i_intr;
            i_wb_pc        = $urandom;
            i_wb_bd        = 1'($urandom);
            i_cop0_ivtbase = 22'($urandom);
            #4;
            want = ref_out();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, obs, want);
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_priority_bd();
        test_interrupt();
        test_stall();
        test_reset_mid_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
